rr_priority_encoder: RTL and testbench
======================================

Name: rr_priority_encoder

Overview:
- Parametrised, registered N-input priority encoder with handshake.
- Selects one active request line, presents its binary index with a valid flag, and holds that grant until the consumer acknowledges it.
- Supports fixed (highest-index-wins) or round-robin priority, and flags multi-request contention.
- Used wherever one of several requesters must be encoded and serviced in turn, e.g. interrupt or channel selection.

Parameters:
- N, 4, number of request lines; legal range 2..64, power of two not required.
- W, $clog2(N), width of the index output; derived, not overridden.
- RR_MODE, 0, selects priority: 0 = fixed, highest index wins; 1 = round-robin, search starts at pointer and wraps.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- req  input  N  request lines, one bit per requester, sampled every clock.
- ack  input  1  consumer accepts current grant; meaningful only while valid=1.
- out  output  W  registered binary index of the granted request.
- valid  output  1  registered; out holds a live grant.
- multi  output  1  registered; more than one req bit was set when the current grant was taken.

Behaviour:
- All state updates occur on the rising edge of clk; rst has priority over every other event.
- Reset:
  - out=0, valid=0, multi=0.
  - Round-robin pointer ptr=0.
  - FSM enters IDLE.
  - Reset asserted mid-grant discards the grant; ack in that cycle is ignored.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE; out=0, valid=0, multi=0.
  - If req!=0, compute the winner, load out=winner, valid=1, multi=(popcount(req)>1), and go to GRANT.
  - Latency: 1 clock from req sampled to valid high.
- Winner selection:
  - RR_MODE=0: the highest set index of req.
  - RR_MODE=1: the first set index found searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Wrap is modulo N, correct for non-power-of-two N.
- GRANT, ack=0:
  - out, valid and multi hold unchanged.
  - Changes on req are ignored, including the granted bit dropping; the grant is sticky.
- GRANT, ack=1:
  - RR_MODE=1: ptr becomes (out+1) mod N. In RR_MODE=0, ptr is unused and holds 0.
  - If req!=0 in the ack cycle, re-arbitrate using the updated ptr and load the new out, valid=1 and multi. Stay in GRANT. This gives back-to-back grants with no idle cycle.
  - If req==0 in the ack cycle: valid=0, out=0, multi=0, go to IDLE.
  - The just-granted line is eligible again. In round-robin it has the lowest priority, so it wins only if it is the sole requester.
- ack while valid=0 is ignored, with no pointer update.
- Multi-request contention never suppresses valid. It only sets multi, as a diagnostic of contention at grant time.
- out never exceeds N-1.
- No combinational path from req or ack to any output.

Test Plan:
- Empty input, N=4, RR_MODE=0: after reset, hold req=0000 for 5 clocks -> out=00, valid=0, multi=0 every cycle.
- Fixed priority, N=4, RR_MODE=0: req=1010 from IDLE -> next clock out=11, valid=1, multi=1. Ack, with req=0010 in the same cycle -> next clock out=01, valid=1, multi=0.
- Round-robin fairness, N=4, RR_MODE=1: req=1111 held, ack=1 every cycle after the first grant -> out sequence 00,01,10,11,00 on consecutive clocks, valid constantly 1, multi=1.
- Sticky grant, N=4, RR_MODE=1: req=0100 for one clock, then req=0000 with ack=0 for 3 clocks -> out=10, valid=1 held all 3 clocks. Ack -> next clock valid=0, out=00.
- Non-power-of-two wrap, N=5, RR_MODE=1: drive req=10000 and ack until out=100 is granted, then ack with req=10001 -> next clock out=000 (ptr wrapped 4->0).
- Reset mid-operation, N=4, RR_MODE=1: with a grant out=10, valid=1 live, assert rst together with ack=1 -> next clock out=00, valid=0, multi=0, ptr=0. With req=1111 after reset release -> first grant out=00.

Source files
------------

// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder: registered N-input priority encoder with a sticky
// grant and an ack handshake. Fixed mode always picks the highest set index.
// Round-robin mode searches upward from a rotating pointer and wraps modulo N.
//
// Handshake: valid=1 means out holds a live grant. The grant stays unchanged
// until the cycle in which ack=1 is sampled with valid=1. In that cycle the
// grant is retired, and either a new grant is loaded (req!=0) or the block
// returns to idle (req==0). An ack sampled while valid=0 has no effect.
module rr_priority_encoder #(
  parameter int N       = 4,
  parameter int W       = $clog2(N),
  parameter int RR_MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [W-1:0] out,
  output logic         valid,
  output logic         multi,
  output logic [0:0]   o_dbg_state,
  output logic [W-1:0] o_dbg_ptr
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]   r_state;
  logic [W-1:0] r_out;
  logic         r_valid;
  logic         r_multi;
  logic [W-1:0] r_ptr;

  logic [W-1:0] w_ptr_next;
  logic [W-1:0] w_ptr_search;
  logic         w_retire;
  logic [W-1:0] w_win;
  logic         w_found;
  logic [W:0]   w_idx;
  logic         w_any;
  logic         w_multi;

  // A grant is retired only when ack arrives while that grant is live.
  assign w_retire = (r_state == S_GRANT) && ack;

  // The just-granted line moves to the lowest round-robin priority.
  assign w_ptr_next = (r_out == W'(N - 1)) ? '0 : r_out + W'(1);

  // Re-arbitration in the ack cycle must already see the advanced pointer.
  assign w_ptr_search = w_retire ? w_ptr_next : r_ptr;

  assign w_any   = |req;
  // More than one bit is set exactly when clearing the lowest set bit leaves something.
  assign w_multi = (req & (req - N'(1))) != '0;

  // Winner search: highest index in fixed mode, first set index from the pointer in round-robin.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    if (RR_MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) w_win = W'(i);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        w_idx = {1'b0, w_ptr_search} + (W+1)'(k);
        if (w_idx >= (W+1)'(N)) w_idx = w_idx - (W+1)'(N);
        if (!w_found && req[w_idx[W-1:0]]) begin
          w_found = 1'b1;
          w_win   = w_idx[W-1:0];
        end
      end
    end
  end

  // Grant FSM with the registered outputs and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_out   <= w_win;
            r_valid <= 1'b1;
            r_multi <= w_multi;
            r_state <= S_GRANT;
          end else begin
            r_out   <= '0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
          end
        end
        S_GRANT: begin
          if (ack) begin
            if (RR_MODE != 0) r_ptr <= w_ptr_next;
            if (w_any) begin
              r_out   <= w_win;
              r_valid <= 1'b1;
              r_multi <= w_multi;
            end else begin
              r_out   <= '0;
              r_valid <= 1'b0;
              r_multi <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_out   <= '0;
          r_valid <= 1'b0;
          r_multi <= 1'b0;
        end
      endcase
    end
  end

  assign out         = r_out;
  assign valid       = r_valid;
  assign multi       = r_multi;
  assign o_dbg_state = r_state;
  assign o_dbg_ptr   = r_ptr;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Bench for rr_priority_encoder. Three instances: N=4 fixed, N=4 round-robin,
// and N=5 round-robin. A directed vector table drives them cycle by cycle.
// Hand-written sequences cover reset and reset asserted mid-grant.
module tb_rr_priority_encoder;

  typedef struct {
    int         dut;
    logic [7:0] req;
    logic       ack;
    int         exp_out;
    int         exp_valid;
    int         exp_multi;
    int         exp_ptr;   // -1: do not check
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: N=4, fixed priority.
  logic       a_rst, a_ack, a_valid, a_multi;
  logic [3:0] a_req;
  logic [1:0] a_out, a_ptr;
  logic [0:0] a_state;
  // DUT B: N=4, round-robin.
  logic       b_rst, b_ack, b_valid, b_multi;
  logic [3:0] b_req;
  logic [1:0] b_out, b_ptr;
  logic [0:0] b_state;
  // DUT C: N=5, round-robin.
  logic       c_rst, c_ack, c_valid, c_multi;
  logic [4:0] c_req;
  logic [2:0] c_out, c_ptr;
  logic [0:0] c_state;

  rr_priority_encoder #(.N(4), .RR_MODE(0)) u_a (
    .clk(clk), .rst(a_rst), .req(a_req), .ack(a_ack), .out(a_out),
    .valid(a_valid), .multi(a_multi), .o_dbg_state(a_state), .o_dbg_ptr(a_ptr));
  rr_priority_encoder #(.N(4), .RR_MODE(1)) u_b (
    .clk(clk), .rst(b_rst), .req(b_req), .ack(b_ack), .out(b_out),
    .valid(b_valid), .multi(b_multi), .o_dbg_state(b_state), .o_dbg_ptr(b_ptr));
  rr_priority_encoder #(.N(5), .RR_MODE(1)) u_c (
    .clk(clk), .rst(c_rst), .req(c_req), .ack(c_ack), .out(c_out),
    .valid(c_valid), .multi(c_multi), .o_dbg_state(c_state), .o_dbg_ptr(c_ptr));

  int checks = 0;
  int passed = 0;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else
      passed++;
  endtask

  function automatic void add(input int dut, input logic [7:0] req, input logic ack,
                              input int o, input int v, input int m, input int p);
    vec_t t;
    t.dut = dut; t.req = req; t.ack = ack;
    t.exp_out = o; t.exp_valid = v; t.exp_multi = m; t.exp_ptr = p;
    vecs.push_back(t);
  endfunction

  // Read one instance's outputs into plain ints.
  task automatic sample(input int dut, output int o, output int v, output int m,
                        output int p, output int s);
    case (dut)
      0: begin o = int'(a_out); v = int'(a_valid); m = int'(a_multi); p = int'(a_ptr); s = int'(a_state); end
      1: begin o = int'(b_out); v = int'(b_valid); m = int'(b_multi); p = int'(b_ptr); s = int'(b_state); end
      default: begin o = int'(c_out); v = int'(c_valid); m = int'(c_multi); p = int'(c_ptr); s = int'(c_state); end
    endcase
  endtask

  // Drive one vector, clock once, and compare 1 ns after the edge.
  task automatic step(input vec_t t, input int idx);
    int o, v, m, p, s;
    a_req = '0; a_ack = 1'b0;
    b_req = '0; b_ack = 1'b0;
    c_req = '0; c_ack = 1'b0;
    case (t.dut)
      0: begin a_req = t.req[3:0]; a_ack = t.ack; end
      1: begin b_req = t.req[3:0]; b_ack = t.ack; end
      default: begin c_req = t.req[4:0]; c_ack = t.ack; end
    endcase
    @(posedge clk);
    #1;
    sample(t.dut, o, v, m, p, s);
    check($sformatf("v%0d_out", idx), o, t.exp_out);
    check($sformatf("v%0d_valid", idx), v, t.exp_valid);
    check($sformatf("v%0d_multi", idx), m, t.exp_multi);
    if (t.exp_ptr >= 0) check($sformatf("v%0d_ptr", idx), p, t.exp_ptr);
  endtask

  initial begin
    int o, v, m, p, s;
    vec_t t;

    // Clock/reset: hold every instance in reset for two edges.
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_req = '0; b_req = '0; c_req = '0;
    a_ack = 1'b1; b_ack = 1'b1; c_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      sample(d, o, v, m, p, s);
      check($sformatf("rst%0d_out", d), o, 0);
      check($sformatf("rst%0d_valid", d), v, 0);
      check($sformatf("rst%0d_multi", d), m, 0);
      check($sformatf("rst%0d_ptr", d), p, 0);
      check($sformatf("rst%0d_state", d), s, 0);
    end
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // Fixed priority, N=4.
    for (int i = 0; i < 5; i++) add(0, 8'b0000, 0, 0, 0, 0, 0);
    add(0, 8'b1010, 0, 3, 1, 1, 0);
    add(0, 8'b0010, 1, 1, 1, 0, 0);
    add(0, 8'b0000, 0, 1, 1, 0, 0);
    add(0, 8'b0000, 1, 0, 0, 0, 0);
    add(0, 8'b0111, 0, 2, 1, 1, 0);
    add(0, 8'b0111, 1, 2, 1, 1, 0);
    add(0, 8'b0000, 1, 0, 0, 0, 0);
    add(0, 8'b0000, 1, 0, 0, 0, 0);
    add(0, 8'b0001, 0, 0, 1, 0, 0);
    add(0, 8'b0000, 1, 0, 0, 0, 0);

    // Round-robin fairness, N=4.
    add(1, 8'b1111, 0, 0, 1, 1, 0);
    add(1, 8'b1111, 1, 1, 1, 1, 1);
    add(1, 8'b1111, 1, 2, 1, 1, 2);
    add(1, 8'b1111, 1, 3, 1, 1, 3);
    add(1, 8'b1111, 1, 0, 1, 1, 0);
    add(1, 8'b0000, 1, 0, 0, 0, 1);
    // Sticky grant: request drops, grant held until ack.
    add(1, 8'b0100, 0, 2, 1, 0, 1);
    add(1, 8'b0000, 0, 2, 1, 0, 1);
    add(1, 8'b0000, 0, 2, 1, 0, 1);
    add(1, 8'b0000, 0, 2, 1, 0, 1);
    add(1, 8'b0000, 1, 0, 0, 0, 3);
    // Ack while idle leaves the pointer alone.
    add(1, 8'b0000, 1, 0, 0, 0, 3);
    // Sole requester wins again after its own ack.
    add(1, 8'b0100, 0, 2, 1, 0, 3);
    add(1, 8'b0100, 1, 2, 1, 0, 3);
    add(1, 8'b0110, 1, 1, 1, 1, 3);
    add(1, 8'b0100, 1, 2, 1, 0, 2);

    // Non-power-of-two wrap, N=5.
    add(2, 8'b10000, 0, 4, 1, 0, 0);
    add(2, 8'b10001, 1, 0, 1, 1, 0);
    add(2, 8'b00000, 1, 0, 0, 0, 1);
    add(2, 8'b11111, 0, 1, 1, 1, 1);
    add(2, 8'b11111, 1, 2, 1, 1, 2);
    add(2, 8'b11111, 1, 3, 1, 1, 3);
    add(2, 8'b11111, 1, 4, 1, 1, 4);
    add(2, 8'b11111, 1, 0, 1, 1, 0);
    add(2, 8'b00000, 1, 0, 0, 0, 1);

    foreach (vecs[i]) step(vecs[i], i);

    // Reset mid-grant on B (out=2 live): ack in the reset cycle is ignored.
    b_rst = 1'b1; b_ack = 1'b1; b_req = 4'b1111;
    @(posedge clk);
    #1;
    sample(1, o, v, m, p, s);
    check("midrst_out", o, 0);
    check("midrst_valid", v, 0);
    check("midrst_multi", m, 0);
    check("midrst_ptr", p, 0);
    check("midrst_state", s, 0);
    b_rst = 1'b0;
    t.dut = 1; t.req = 8'b1111; t.ack = 1'b0;
    t.exp_out = 0; t.exp_valid = 1; t.exp_multi = 1; t.exp_ptr = 0;
    step(t, 900);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
